// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: button conditioning and run/pause/lap/expired sequencing for the min/sec stopwatch.
// Optional define EXPIRE_BLINK_EN blinks the decimal points while in EXPIRED.

module stop_watch_ctrl #(
  parameter int DB_TICKS    = 1_000_000,
  parameter int DB_W        = 20,
  parameter int BLINK_TICKS = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_start,
  input  logic       i_btn_lap,
  input  logic       i_btn_clr,
  input  logic       i_dir_sw,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d0,
  output logic       o_go,
  output logic       o_clr,
  output logic       o_direc,
  output logic [3:0] o_hex3,
  output logic [3:0] o_hex2,
  output logic [3:0] o_hex1,
  output logic [3:0] o_hex0,
  output logic [3:0] o_dp_out,
  output logic       o_lap_act,
  output logic       o_expired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_EXPIRED
  } stateT;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TICKS - 1);

  if ((2 ** DB_W) <= DB_TICKS) begin : g_dbWidthCheck
    $error("stop_watch_ctrl: DB_W too narrow to count DB_TICKS");
  end
  if (BLINK_TICKS < 1) begin : g_blinkCheck
    $error("stop_watch_ctrl: BLINK_TICKS must be at least 1");
  end

  // Button bit order everywhere: [0]=start, [1]=lap, [2]=clr
  logic [2:0]      w_btnRaw;
  logic [2:0]      r_syncA;
  logic [2:0]      r_syncB;
  logic [2:0]      r_dbLevel;
  logic [2:0]      r_press;
  logic [DB_W-1:0] r_dbCnt [0:2];
  logic            r_dirSyncA;
  logic            r_dirSyncB;

  assign w_btnRaw = {i_btn_clr, i_btn_lap, i_btn_start};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_syncA   <= '0;
      r_syncB   <= '0;
      r_dbLevel <= '0;
      r_press   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      r_syncA <= w_btnRaw;
      r_syncB <= r_syncA;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (r_syncB[i] == r_dbLevel[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_LAST) begin
          r_dbCnt[i]   <= '0;
          r_dbLevel[i] <= r_syncB[i];
          r_press[i]   <= r_syncB[i];
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
        end
      end
    end
  end

  // The direction switch is a slow lever, so it only needs metastability protection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dirSyncA <= 1'b1;
      r_dirSyncB <= 1'b1;
    end else begin
      r_dirSyncA <= i_dir_sw;
      r_dirSyncB <= r_dirSyncA;
    end
  end

  logic        w_startP;
  logic        w_lapP;
  logic        w_clrP;
  logic        w_zero;
  logic        w_expire;
  stateT       r_state;
  stateT       w_nextState;
  logic        w_latchLap;
  logic        r_go;
  logic        r_clr;
  logic        r_lapAct;
  logic        r_expired;
  logic        r_direc;
  logic [15:0] r_lapDigits;

  assign w_startP = r_press[0];
  assign w_lapP   = r_press[1];
  assign w_clrP   = r_press[2];
  assign w_zero   = ({i_d3, i_d2, i_d1, i_d0} == 16'h0000);
  assign w_expire = ~r_direc & w_zero;

  // Priority inside each state: clr, then expiry, then start, then lap
  always_comb begin
    w_nextState = r_state;
    w_latchLap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clrP) begin
          w_nextState = S_IDLE;
        end else if (w_startP && !(!r_dirSyncB && w_zero)) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (w_clrP) begin
          w_nextState = S_IDLE;
        end else if (w_expire) begin
          w_nextState = S_EXPIRED;
        end else if (w_startP) begin
          w_nextState = S_PAUSE;
        end else if (w_lapP) begin
          w_nextState = S_LAP;
          w_latchLap  = 1'b1;
        end
      end
      S_LAP: begin
        if (w_clrP) begin
          w_nextState = S_IDLE;
        end else if (w_expire) begin
          w_nextState = S_EXPIRED;
        end else if (w_startP) begin
          w_nextState = S_PAUSE;
        end else if (w_lapP) begin
          w_nextState = S_RUN;
        end
      end
      S_PAUSE: begin
        if (w_clrP) begin
          w_nextState = S_IDLE;
        end else if (w_startP) begin
          w_nextState = S_RUN;
        end
      end
      S_EXPIRED: begin
        if (w_clrP) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_go        <= 1'b0;
      r_clr       <= 1'b0;
      r_lapAct    <= 1'b0;
      r_expired   <= 1'b0;
      r_direc     <= 1'b1;
      r_lapDigits <= '0;
    end else begin
      r_state   <= w_nextState;
      r_go      <= (w_nextState == S_RUN) || (w_nextState == S_LAP);
      r_clr     <= w_clrP;
      r_lapAct  <= (w_nextState == S_LAP);
      r_expired <= (w_nextState == S_EXPIRED);
      if ((r_state == S_IDLE) || (r_state == S_PAUSE)) begin
        r_direc <= r_dirSyncB;
      end
      if (w_latchLap) begin
        r_lapDigits <= {i_d3, i_d2, i_d1, i_d0};
      end
    end
  end

  assign o_go      = r_go;
  assign o_clr     = r_clr;
  assign o_direc   = r_direc;
  assign o_lap_act = r_lapAct;
  assign o_expired = r_expired;
  assign o_hex3    = r_lapAct ? r_lapDigits[15:12] : i_d3;
  assign o_hex2    = r_lapAct ? r_lapDigits[11:8]  : i_d2;
  assign o_hex1    = r_lapAct ? r_lapDigits[7:4]   : i_d1;
  assign o_hex0    = r_lapAct ? r_lapDigits[3:0]   : i_d0;

`ifdef EXPIRE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_blinkPhase;

  // Phase 0 (dots dark) always starts on the entry edge into EXPIRED
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if ((w_nextState == S_EXPIRED) && (r_state != S_EXPIRED)) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (r_state == S_EXPIRED) begin
      if (r_blinkCnt == BLINK_LAST) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
      end
    end
  end

  assign o_dp_out = (r_expired && !r_blinkPhase) ? 4'b0000 : 4'b0101;
`else
  assign o_dp_out = 4'b0101;
`endif

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Scoreboard bench for stop_watch_ctrl: expectations are queued with a target cycle when stimulus
// is driven and compared by a monitor 1 time unit after that rising edge.

module tb_stop_watch_ctrl;

  localparam int DB_TICKS    = 4;
  localparam int DB_W        = 3;
  localparam int BLINK_TICKS = 8;
  localparam int LAT         = DB_TICKS + 3;
  localparam int SETTLE      = DB_TICKS + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnStart;
  logic       btnLap;
  logic       btnClr;
  logic       dirSw;
  logic [3:0] d3, d2, d1, d0;
  logic       goOut;
  logic       clrOut;
  logic       direcOut;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dpOut;
  logic       lapActOut;
  logic       expiredOut;

  stop_watch_ctrl #(
    .DB_TICKS   (DB_TICKS),
    .DB_W       (DB_W),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_btn_start(btnStart),
    .i_btn_lap  (btnLap),
    .i_btn_clr  (btnClr),
    .i_dir_sw   (dirSw),
    .i_d3       (d3),
    .i_d2       (d2),
    .i_d1       (d1),
    .i_d0       (d0),
    .o_go       (goOut),
    .o_clr      (clrOut),
    .o_direc    (direcOut),
    .o_hex3     (hex3),
    .o_hex2     (hex2),
    .o_hex1     (hex1),
    .o_hex0     (hex0),
    .o_dp_out   (dpOut),
    .o_lap_act  (lapActOut),
    .o_expired  (expiredOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {F_GO, F_CLR, F_DIREC, F_LAPACT, F_EXPIRED, F_HEX, F_DP} fieldT;
  typedef struct {
    int          cycle;
    string       tag;
    fieldT       field;
    logic [15:0] expected;
  } expectT;

  expectT scoreQ[$];
  int checksDone   = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  function automatic logic [15:0] fieldValue(input fieldT f);
    case (f)
      F_GO:      return {15'b0, goOut};
      F_CLR:     return {15'b0, clrOut};
      F_DIREC:   return {15'b0, direcOut};
      F_LAPACT:  return {15'b0, lapActOut};
      F_EXPIRED: return {15'b0, expiredOut};
      F_HEX:     return {hex3, hex2, hex1, hex0};
      default:   return {12'b0, dpOut};
    endcase
  endfunction

  task automatic expectAt(input int delta, input string tag, input fieldT f, input logic [15:0] v);
    expectT e;
    e.cycle    = cyc + delta;
    e.tag      = tag;
    e.field    = f;
    e.expected = v;
    scoreQ.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #1;
    for (int i = scoreQ.size() - 1; i >= 0; i--) begin
      if (scoreQ[i].cycle == cyc) begin
        checkOutput(scoreQ[i].tag, fieldValue(scoreQ[i].field), scoreQ[i].expected);
        scoreQ.delete(i);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setDigits(input logic [15:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  // btns = {clr, lap, start}; called at a falling edge, returns at a falling edge with buttons settled
  task automatic applyStimulus(input logic [2:0] btns, input int hold);
    {btnClr, btnLap, btnStart} = btns;
    waitCycles(hold);
    {btnClr, btnLap, btnStart} = 3'b000;
    waitCycles(SETTLE);
  endtask

  task automatic checkResetValues(input string tag, input logic [15:0] hexExp);
    checkOutput({tag, "Go"}, {15'b0, goOut}, 16'd0);
    checkOutput({tag, "Clr"}, {15'b0, clrOut}, 16'd0);
    checkOutput({tag, "Direc"}, {15'b0, direcOut}, 16'd1);
    checkOutput({tag, "LapAct"}, {15'b0, lapActOut}, 16'd0);
    checkOutput({tag, "Expired"}, {15'b0, expiredOut}, 16'd0);
    checkOutput({tag, "Dp"}, {12'b0, dpOut}, 16'h0005);
    checkOutput({tag, "Hex"}, {hex3, hex2, hex1, hex0}, hexExp);
  endtask

  initial begin
    reset = 1'b1;
    {btnClr, btnLap, btnStart} = 3'b000;
    dirSw = 1'b1;
    setDigits(16'h1234);
    waitCycles(3);
    checkResetValues("reset", 16'h1234);
    reset = 1'b0;
    waitCycles(3);

    // Short glitch must be rejected, then a solid hold starts the watch after LAT edges
    for (int k = 1; k <= 10; k++) expectAt(k, "glitchGo", F_GO, 16'd0);
    applyStimulus(3'b001, 2);
    for (int k = 1; k <= LAT + 4; k++) expectAt(k, "startLatencyGo", F_GO, (k >= LAT) ? 16'd1 : 16'd0);
    applyStimulus(3'b001, 10);

    // Lap freeze while the counter keeps moving
    applyStimulus(3'b010, 8);
    setDigits(16'h1240);
    expectAt(1, "lapHexFrozen", F_HEX, 16'h1234);
    expectAt(1, "lapActive", F_LAPACT, 16'd1);
    expectAt(1, "lapGo", F_GO, 16'd1);
    waitCycles(2);
    applyStimulus(3'b010, 8);
    expectAt(1, "lapReleaseHex", F_HEX, 16'h1240);
    expectAt(1, "lapReleaseAct", F_LAPACT, 16'd0);
    expectAt(1, "lapReleaseGo", F_GO, 16'd1);
    waitCycles(2);

    // Pause, then clear from PAUSE and again from IDLE
    applyStimulus(3'b001, 8);
    expectAt(1, "pauseGo", F_GO, 16'd0);
    waitCycles(2);
    expectAt(LAT - 1, "pauseClrBefore", F_CLR, 16'd0);
    expectAt(LAT, "pauseClrPulse", F_CLR, 16'd1);
    expectAt(LAT + 1, "pauseClrAfter", F_CLR, 16'd0);
    applyStimulus(3'b100, 8);
    expectAt(LAT, "idleClrPulse", F_CLR, 16'd1);
    expectAt(LAT + 1, "idleClrAfter", F_CLR, 16'd0);
    expectAt(LAT + 1, "idleClrGo", F_GO, 16'd0);
    applyStimulus(3'b100, 8);

    // Count-down: start refused at 0000, then expiry from 0003
    dirSw = 1'b0;
    setDigits(16'h0000);
    waitCycles(4);
    expectAt(1, "idleDirecFollows", F_DIREC, 16'd0);
    waitCycles(1);
    applyStimulus(3'b001, 8);
    expectAt(1, "zeroStartIgnored", F_GO, 16'd0);
    waitCycles(1);
    setDigits(16'h0003);
    applyStimulus(3'b001, 8);
    expectAt(1, "downRunGo", F_GO, 16'd1);
    waitCycles(1);
    setDigits(16'h0002);
    waitCycles(1);
    setDigits(16'h0001);
    expectAt(1, "downAt0001Go", F_GO, 16'd1);
    waitCycles(1);
    setDigits(16'h0000);
    expectAt(1, "expireGo", F_GO, 16'd0);
    expectAt(1, "expireFlag", F_EXPIRED, 16'd1);
`ifdef EXPIRE_BLINK_EN
    expectAt(1, "blinkEntry", F_DP, 16'h0000);
    expectAt(BLINK_TICKS, "blinkDarkEnd", F_DP, 16'h0000);
    expectAt(BLINK_TICKS + 1, "blinkLit", F_DP, 16'h0005);
    expectAt(2 * BLINK_TICKS, "blinkLitEnd", F_DP, 16'h0005);
    expectAt(2 * BLINK_TICKS + 1, "blinkDarkAgain", F_DP, 16'h0000);
`else
    expectAt(1, "expireDpSteady", F_DP, 16'h0005);
`endif
    waitCycles(2 * BLINK_TICKS + 3);
    applyStimulus(3'b001, 8);
    expectAt(1, "expiredStartIgnoredGo", F_GO, 16'd0);
    expectAt(1, "expiredStartIgnoredFlag", F_EXPIRED, 16'd1);
    waitCycles(1);
    applyStimulus(3'b010, 8);
    expectAt(1, "expiredLapIgnored", F_LAPACT, 16'd0);
    waitCycles(1);
    expectAt(LAT, "expiredClrPulse", F_CLR, 16'd1);
    expectAt(LAT, "expiredClrFlag", F_EXPIRED, 16'd0);
    expectAt(LAT + 1, "expiredClrAfter", F_CLR, 16'd0);
    applyStimulus(3'b100, 8);
    expectAt(1, "afterClrDp", F_DP, 16'h0005);
    waitCycles(1);

    // clr and start together in RUN: clr wins, no pause
    dirSw = 1'b1;
    setDigits(16'h0100);
    waitCycles(4);
    applyStimulus(3'b001, 8);
    expectAt(LAT - 1, "comboGoBefore", F_GO, 16'd1);
    expectAt(LAT, "comboGo", F_GO, 16'd0);
    expectAt(LAT, "comboClr", F_CLR, 16'd1);
    expectAt(LAT + 1, "comboClrAfter", F_CLR, 16'd0);
    applyStimulus(3'b101, 8);

    // Direction held during RUN, taken up in PAUSE
    applyStimulus(3'b001, 8);
    dirSw = 1'b0;
    waitCycles(6);
    expectAt(1, "runDirecHeld", F_DIREC, 16'd1);
    waitCycles(1);
    expectAt(LAT, "pauseDirecNotYet", F_DIREC, 16'd1);
    expectAt(LAT + 3, "pauseDirecFollows", F_DIREC, 16'd0);
    applyStimulus(3'b001, 8);
    dirSw = 1'b1;
    waitCycles(4);
    applyStimulus(3'b001, 8);
    setDigits(16'h1234);
    waitCycles(1);
    applyStimulus(3'b010, 8);
    setDigits(16'h5678);
    expectAt(1, "preResetHex", F_HEX, 16'h1234);
    expectAt(1, "preResetGo", F_GO, 16'd1);
    waitCycles(2);

    // Asynchronous reset in the middle of a lap
    reset = 1'b1;
    #1;
    checkResetValues("midLapReset", 16'h5678);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(3);

    checkOutput("scoreboardDrained", 16'(scoreQ.size()), 16'd0);
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
